// File: rtl/ecc_pkg.sv
// Shared types for the modular arithmetic units: operation select and the
// two-pass limb-serial add/sub controller states.
package ecc_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/limb_addsub.sv
// Combinational LIMB-bit adder/subtractor; cin/cout are carry when sub=0 and
// borrow when sub=1. Zero latency, no flow control.
module limb_addsub #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] x,
  input  logic [LIMB-1:0] y,
  input  logic            sub,
  input  logic            cin,
  output logic [LIMB-1:0] s,
  output logic            cout
);

  logic [LIMB:0] sum_ext;

  // One extra bit holds the carry out, or the borrow as a wrapped sign bit.
  always_comb begin
    if (sub) sum_ext = {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, cin};
    else     sum_ext = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, cin};
  end

  assign s    = sum_ext[LIMB-1:0];
  assign cout = sum_ext[LIMB];

endmodule

// File: rtl/mod_addsub_unit.sv
// Modular (a+b) or (a-b) mod p, one limb per cycle over two passes: result
// valid 2*NUM_LIMBS edges after accept; held in DONE until ready_i, ready_o only in IDLE.
module mod_addsub_unit
  import ecc_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int NUM_LIMBS = WIDTH / LIMB;
  localparam int IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  if (LIMB < 8 || WIDTH < LIMB || (WIDTH % LIMB) != 0) begin : g_param_chk
    $error("mod_addsub_unit: WIDTH must be a nonzero multiple of LIMB and LIMB >= 8");
  end

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, p_q, raw_q, t_q, result_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q, c1_q;

  logic [LIMB-1:0]  lx, ly, ls;
  logic             lsub, lcout, last, sel;
  logic [WIDTH-1:0] raw_next, t_next;
  int unsigned      base;

  assign base = int'(idx_q) * LIMB;
  assign last = (idx_q == IDX_W'(NUM_LIMBS - 1));

  // Pass 1 forms raw = a op b; pass 2 applies the opposite op with p to raw.
  always_comb begin
    lx   = (state_q == PASS1) ? a_q[base +: LIMB] : raw_q[base +: LIMB];
    ly   = (state_q == PASS1) ? b_q[base +: LIMB] : p_q[base +: LIMB];
    lsub = (state_q == PASS1) ? (op_q == OP_SUB) : (op_q == OP_ADD);
  end

  limb_addsub #(.LIMB(LIMB)) u_limb (
    .x    (lx),
    .y    (ly),
    .sub  (lsub),
    .cin  (carry_q),
    .s    (ls),
    .cout (lcout)
  );

  always_comb begin
    raw_next               = raw_q;
    raw_next[base +: LIMB] = ls;
    t_next                 = t_q;
    t_next[base +: LIMB]   = ls;
  end

  // lcout here is the pass-2 carry/borrow of the top limb (c2).
  assign sel = (op_q == OP_ADD) ? (c1_q | ~lcout) : c1_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      raw_q    <= '0;
      t_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            op_q    <= op_e'(op_i);
            a_q     <= a_i;
            b_q     <= b_i;
            p_q     <= p_i;
            idx_q   <= '0;
            carry_q <= 1'b0;
            state_q <= PASS1;
          end
        end
        PASS1: begin
          raw_q <= raw_next;
          if (last) begin
            c1_q    <= lcout;
            carry_q <= 1'b0;
            idx_q   <= '0;
            state_q <= PASS2;
          end else begin
            carry_q <= lcout;
            idx_q   <= idx_q + 1'b1;
          end
        end
        PASS2: begin
          t_q <= t_next;
          if (last) begin
            result_q <= sel ? t_next : raw_q;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            state_q  <= DONE;
          end else begin
            carry_q <= lcout;
            idx_q   <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mod_addsub_unit.sv
// Directed-vector bench for mod_addsub_unit at WIDTH=256, LIMB=64, p=2^255-19.
module tb_mod_addsub_unit;
  localparam int W = 256;
  localparam logic [W-1:0] P = {1'b0, {247{1'b1}}, 8'hED};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i, ready_o, op_i, valid_o, ready_i;
  logic [W-1:0] a_i, b_i, p_i, result_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_addsub_unit #(.WIDTH(256), .LIMB(64)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .p_i      (p_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called #1 after the accepting edge; counts edges until valid_o rises.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!valid_o && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic do_op(input string tag, input logic op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int hold);
    int edges;
    @(negedge clk);
    check({tag, "_ready_before"}, W'(ready_o), W'(1));
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; p_i = P; ready_i = 1'b0;
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the result must not depend on them.
    valid_i = 1'b0; op_i = ~op; a_i = ~a; b_i = ~b; p_i = ~P;
    wait_valid(edges);
    check({tag, "_latency"}, W'(edges), W'(8));
    check({tag, "_result"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, W'(valid_o), W'(1));
      check({tag, "_hold_ready"}, W'(ready_o), W'(0));
      check({tag, "_hold_result"}, result_o, exp);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    check({tag, "_idle_valid"}, W'(valid_o), W'(0));
    check({tag, "_idle_ready"}, W'(ready_o), W'(1));
    check({tag, "_idle_result"}, result_o, exp);
  endtask

  initial begin
    int edges, pulses;
    logic [W-1:0] two64;
    two64 = '0;
    two64[64] = 1'b1;
    rst_n = 1'b0; valid_i = 1'b0; op_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; p_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_ready", W'(ready_o), W'(1));
    check("reset_valid", W'(valid_o), W'(0));
    check("reset_result", result_o, '0);

    do_op("sub_5_3",   1'b1, W'(5), W'(3), W'(2), 5);
    do_op("sub_3_5",   1'b1, W'(3), W'(5), P - W'(2), 0);
    do_op("add_pm1_1", 1'b0, P - W'(1), W'(1), '0, 0);
    do_op("add_pm1_pm1", 1'b0, P - W'(1), P - W'(1), P - W'(2), 0);
    do_op("sub_limb_borrow", 1'b1, two64, W'(1), two64 - W'(1), 0);
    do_op("add_7_8",   1'b0, W'(7), W'(8), W'(15), 0);
    do_op("add_wrap",  1'b0, P - W'(3), W'(5), W'(2), 0);

    // Reset during PASS2 aborts the request silently.
    @(negedge clk);
    valid_i = 1'b1; op_i = 1'b0; a_i = W'(100); b_i = W'(200); p_i = P;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_ready", W'(ready_o), W'(1));
    check("abort_valid", W'(valid_o), W'(0));
    check("abort_result", result_o, '0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) pulses++;
    end
    check("abort_no_pulse", W'(pulses), W'(0));

    // Back-to-back with valid_i held high through the handshake.
    @(negedge clk);
    valid_i = 1'b1; op_i = 1'b0; a_i = W'(10); b_i = W'(20); p_i = P; ready_i = 1'b0;
    @(posedge clk);
    #1;
    a_i = W'(50); b_i = W'(8); op_i = 1'b1;
    wait_valid(edges);
    check("b2b_first_latency", W'(edges), W'(8));
    check("b2b_first_result", result_o, W'(30));
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_gap_ready", W'(ready_o), W'(1));
    check("b2b_gap_valid", W'(valid_o), W'(0));
    @(posedge clk);
    #1;
    check("b2b_second_accepted", W'(ready_o), W'(0));
    valid_i = 1'b0;
    wait_valid(edges);
    check("b2b_second_latency", W'(edges), W'(8));
    check("b2b_second_result", result_o, W'(42));
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    check("b2b_end_ready", W'(ready_o), W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
